// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared types and constants for the USB2 HS receive deserializer.
//   rx_state_e  : receiver FSM states (IDLE, RX, ABORT)
//   STUFF_LIMIT : decoded-one run length after which a stuffed zero follows
//   EOP_ONES    : consecutive decoded ones that end the ABORT state
//   LEN_W       : width of the packet byte counter
package usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RX    = 2'd1,
    ABORT = 2'd2
  } rx_state_e;

  localparam int STUFF_LIMIT = 6;
  localparam int EOP_ONES    = 7;
  localparam int LEN_W       = 11;

endpackage

// File: rtl/usb_nrzi_unstuff.sv
// usb_nrzi_unstuff: NRZI decoder plus bit-unstuffing classifier.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bit_in      : recovered line bit
//   bit_en      : bit_in valid this cycle (low = stall, nothing changes)
//   rx_mode     : receiver is inside a packet, so unstuffing applies
//   dbit        : NRZI-decoded bit of the current line bit (combinational)
//   dbit_valid  : dbit is a payload data bit
//   stuff_drop  : current bit is a stuffed zero to be discarded
//   stuff_viol  : current bit is a stuffing violation (end of packet)
module usb_nrzi_unstuff
  import usb_rx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic bit_in,
  input  logic bit_en,
  input  logic rx_mode,
  output logic dbit,
  output logic dbit_valid,
  output logic stuff_drop,
  output logic stuff_viol
);

  logic       prev_q, prev_d;
  logic [2:0] ones_q, ones_d;
  logic       at_limit;

  always_comb begin
    dbit       = ~(bit_in ^ prev_q);
    prev_d     = bit_en ? bit_in : prev_q;
    at_limit   = (ones_q == 3'(STUFF_LIMIT));
    stuff_drop = bit_en & rx_mode & ~dbit & at_limit;
    stuff_viol = bit_en & rx_mode &  dbit & at_limit;
    dbit_valid = bit_en & rx_mode & ~at_limit;

    // Run counter only lives inside a packet; a zero, a stuffed zero or the
    // violating one all restart it, so the next packet starts from zero.
    ones_d = ones_q;
    if (bit_en) begin
      if (!rx_mode || !dbit || at_limit) begin
        ones_d = 3'd0;
      end else begin
        ones_d = ones_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      ones_q <= 3'd0;
    end else begin
      prev_q <= prev_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/usb_rx_deserializer.sv
// usb_rx_deserializer: USB2 HS receive byte recovery (NRZI decode, SYNC hunt,
// unstuffing, LSB-first deserialisation, EOP detection).
// Optional feature: define USB_RX_PID_CHECK_EN to flag packets whose first
// byte fails the PID check (low nibble must equal inverted high nibble).
// Parameters:
//   SYNC_MIN  : decoded-zero run (then a one) accepted as SYNC
//   MAX_BYTES : bytes per packet before overflow abort (<= 2047)
// Ports:
//   clock_480 : bit clock
//   reset     : asynchronous active-low reset
//   bit_in    : recovered line bit;   bit_en : bit_in valid (low = stall)
//   rx_data   : last completed byte (LSB first received)
//   rx_valid  : one-cycle strobe, rx_data updated
//   rx_active : high from SYNC accept to EOP/abort
//   rx_eop    : one-cycle strobe, packet ended;  rx_err : packet bad (with rx_eop)
//   rx_len    : bytes delivered in current/last packet
module usb_rx_deserializer
  import usb_rx_pkg::*;
#(
  parameter int SYNC_MIN  = 12,
  parameter int MAX_BYTES = 1027
) (
  input  logic              clock_480,
  input  logic              reset,
  input  logic              bit_in,
  input  logic              bit_en,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  output logic              rx_active,
  output logic              rx_eop,
  output logic              rx_err,
  output logic [LEN_W-1:0]  rx_len
);

  localparam int               ZW      = $clog2(SYNC_MIN + 1);
  localparam logic [ZW-1:0]    ZMAX    = ZW'(SYNC_MIN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BYTES);

  logic dbit, dbit_valid, stuff_drop, stuff_viol;

  rx_state_e        state_q, state_d;
  logic [ZW-1:0]    zcnt_q, zcnt_d;
  logic [7:0]       sr_q, sr_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [2:0]       abort_cnt_q, abort_cnt_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_active_q, rx_active_d;
  logic             rx_eop_q, rx_eop_d;
  logic             rx_err_q, rx_err_d;
  logic [LEN_W-1:0] rx_len_q, rx_len_d;
  logic [7:0]       byte_w;
  logic             pid_flag;

`ifdef USB_RX_PID_CHECK_EN
  logic pid_flag_q, pid_flag_d;
  assign pid_flag = pid_flag_q;
`else
  assign pid_flag = 1'b0;
`endif

  usb_nrzi_unstuff u_nrzi_unstuff (
    .clk        (clock_480),
    .rst_n      (reset),
    .bit_in     (bit_in),
    .bit_en     (bit_en),
    .rx_mode    (state_q == RX),
    .dbit       (dbit),
    .dbit_valid (dbit_valid),
    .stuff_drop (stuff_drop),
    .stuff_viol (stuff_viol)
  );

  always_comb begin
    state_d     = state_q;
    zcnt_d      = zcnt_q;
    sr_d        = sr_q;
    bitcnt_d    = bitcnt_q;
    abort_cnt_d = abort_cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_active_d = rx_active_q;
    rx_eop_d    = 1'b0;
    rx_err_d    = 1'b0;
    rx_len_d    = rx_len_q;
`ifdef USB_RX_PID_CHECK_EN
    pid_flag_d  = pid_flag_q;
`endif
    // Byte as it would be after shifting in the current bit (LSB-first).
    byte_w      = {dbit, sr_q[7:1]};

    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (!dbit) begin
            if (zcnt_q != ZMAX) zcnt_d = zcnt_q + 1'b1;
          end else if (zcnt_q == ZMAX) begin
            state_d     = RX;
            rx_active_d = 1'b1;
            bitcnt_d    = 3'd0;
            rx_len_d    = '0;
            zcnt_d      = '0;
`ifdef USB_RX_PID_CHECK_EN
            pid_flag_d  = 1'b0;
`endif
          end else begin
            zcnt_d = '0;
          end
        end

        RX: begin
          if (stuff_viol) begin
            // End of packet; any partial byte in sr is simply abandoned.
            rx_eop_d    = 1'b1;
            rx_err_d    = (rx_len_q == '0) | pid_flag;
            rx_active_d = 1'b0;
            state_d     = IDLE;
            zcnt_d      = '0;
          end else if (stuff_drop) begin
            // Stuffed zero: no shift, no bit count.
          end else if (dbit_valid) begin
            sr_d     = byte_w;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              if (rx_len_q == LEN_MAX) begin
                rx_eop_d    = 1'b1;
                rx_err_d    = 1'b1;
                rx_active_d = 1'b0;
                state_d     = ABORT;
                abort_cnt_d = 3'd0;
              end else begin
                rx_data_d  = byte_w;
                rx_valid_d = 1'b1;
                rx_len_d   = rx_len_q + 1'b1;
`ifdef USB_RX_PID_CHECK_EN
                if (rx_len_q == '0) pid_flag_d = (byte_w[3:0] != ~byte_w[7:4]);
`endif
              end
            end
          end
        end

        ABORT: begin
          // Stuffed traffic never carries 7 ones in a row, so only the
          // line's EOP can get us out.
          if (dbit) begin
            if (abort_cnt_q == 3'(EOP_ONES - 1)) begin
              state_d     = IDLE;
              zcnt_d      = '0;
              abort_cnt_d = 3'd0;
            end else begin
              abort_cnt_d = abort_cnt_q + 3'd1;
            end
          end else begin
            abort_cnt_d = 3'd0;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_480 or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      zcnt_q      <= '0;
      sr_q        <= 8'h00;
      bitcnt_q    <= 3'd0;
      abort_cnt_q <= 3'd0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_active_q <= 1'b0;
      rx_eop_q    <= 1'b0;
      rx_err_q    <= 1'b0;
      rx_len_q    <= '0;
`ifdef USB_RX_PID_CHECK_EN
      pid_flag_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      zcnt_q      <= zcnt_d;
      sr_q        <= sr_d;
      bitcnt_q    <= bitcnt_d;
      abort_cnt_q <= abort_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_active_q <= rx_active_d;
      rx_eop_q    <= rx_eop_d;
      rx_err_q    <= rx_err_d;
      rx_len_q    <= rx_len_d;
`ifdef USB_RX_PID_CHECK_EN
      pid_flag_q  <= pid_flag_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_active = rx_active_q;
  assign rx_eop    = rx_eop_q;
  assign rx_err    = rx_err_q;
  assign rx_len    = rx_len_q;

endmodule

// File: tb/tb_usb_rx_deserializer.sv
// Testbench for usb_rx_deserializer. Packets are built as byte lists, bit-
// stuffed and NRZI-encoded by the bench; expected byte/EOP events are pushed
// into a scoreboard queue and a negedge monitor pops them as strobes appear.
module tb_usb_rx_deserializer;

  localparam int SYNC_MIN = 12;
  localparam int MAX_B    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bit_in;
  logic        bit_en;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_active;
  logic        rx_eop;
  logic        rx_err;
  logic [10:0] rx_len;

  always #5 clk = ~clk;

  usb_rx_deserializer #(.SYNC_MIN(SYNC_MIN), .MAX_BYTES(MAX_B)) dut (
    .clock_480 (clk),
    .reset     (rst_n),
    .bit_in    (bit_in),
    .bit_en    (bit_en),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_active (rx_active),
    .rx_eop    (rx_eop),
    .rx_err    (rx_err),
    .rx_len    (rx_len)
  );

  typedef struct {
    bit          is_eop;
    logic [7:0]  data;
    bit          err;
    logic [10:0] len;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_ev;
  int         total = 0;
  int         bad   = 0;
  logic       line_prev = 1'b0;
  int         stuff_ones = 0;
  int         gap_pct = 0;
  bit         active_seen = 1'b0;
  logic [7:0] pkt [0:7];
  int         pkt_n = 0;

  function automatic bit pid_bad(input logic [7:0] b);
`ifdef USB_RX_PID_CHECK_EN
    return b[3:0] != ~b[7:4];
`else
    return 1'b0;
`endif
  endfunction

  // Monitor / scoreboard checker.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_active) active_seen = 1'b1;
      if (rx_valid && rx_eop) begin
        total++; bad++;
        $display("FAIL strobe_overlap: rx_valid=1 rx_eop=1, required not both");
      end
      if (rx_err && !rx_eop) begin
        total++; bad++;
        $display("FAIL err_qualify: rx_err=1 with rx_eop=0, required 0");
      end
      if (rx_valid || rx_eop) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_strobe: valid=%0b eop=%0b data=%02h len=%0d, required none",
                   rx_valid, rx_eop, rx_data, rx_len);
        end else begin
          mon_ev = exp_q.pop_front();
          if (rx_valid) begin
            if (mon_ev.is_eop || rx_data !== mon_ev.data || rx_len !== mon_ev.len || rx_active !== 1'b1) begin
              bad++;
              $display("FAIL byte_event: got valid data=%02h len=%0d active=%0b, required %s data=%02h len=%0d active=1",
                       rx_data, rx_len, rx_active, mon_ev.is_eop ? "eop" : "valid", mon_ev.data, mon_ev.len);
            end
          end else begin
            if (!mon_ev.is_eop || rx_err !== mon_ev.err || rx_len !== mon_ev.len || rx_active !== 1'b0) begin
              bad++;
              $display("FAIL eop_event: got eop err=%0b len=%0d active=%0b, required %s err=%0b len=%0d active=0",
                       rx_err, rx_len, rx_active, mon_ev.is_eop ? "eop" : "valid", mon_ev.err, mon_ev.len);
            end
          end
        end
      end
    end
  end

  task automatic push_ev(input bit is_eop, input logic [7:0] d, input bit err, input int len);
    ev_t e;
    e.is_eop = is_eop;
    e.data   = d;
    e.err    = err;
    e.len    = 11'(len);
    exp_q.push_back(e);
  endtask

  // One decoded bit on the line, NRZI encoded, with optional stall cycles.
  task automatic drive_bit(input bit d);
    while (int'($urandom_range(99)) < gap_pct) begin
      bit_en = 1'b0;
      bit_in = 1'($urandom);
      @(posedge clk); #1;
    end
    bit_in    = ~(line_prev ^ d);
    line_prev = bit_in;
    bit_en    = 1'b1;
    @(posedge clk); #1;
    bit_en    = 1'b0;
  endtask

  // Payload bit with a stuffed zero after every sixth consecutive one.
  task automatic send_data_bit(input bit d);
    drive_bit(d);
    if (d) begin
      stuff_ones++;
      if (stuff_ones == 6) begin
        drive_bit(1'b0);
        stuff_ones = 0;
      end
    end else begin
      stuff_ones = 0;
    end
  endtask

  task automatic idle(input int n);
    bit_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string tag);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d events outstanding, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Sends SYNC + pkt[0..pkt_n-1] + EOP and records what the link layer must see.
  task automatic run_packet(input int nz, input int gap, input string tag);
    int ndel;
    bit err;
    ndel = (pkt_n > MAX_B) ? MAX_B : pkt_n;
    for (int i = 0; i < ndel; i++) push_ev(1'b0, pkt[i], 1'b0, i + 1);
    if (pkt_n > MAX_B) err = 1'b1;
    else               err = (pkt_n == 0) || pid_bad(pkt[0]);
    push_ev(1'b1, 8'h00, err, ndel);

    gap_pct = gap;
    repeat (nz) drive_bit(1'b0);
    drive_bit(1'b1);
    stuff_ones = 0;
    for (int i = 0; i < pkt_n; i++)
      for (int b = 0; b < 8; b++) send_data_bit(pkt[i][b]);
    repeat (8) drive_bit(1'b1);
    gap_pct = 0;
    idle(3);
    check_drained(tag);
    $display("pkt %s: zeros=%0d bytes=%0d gap=%0d expect_err=%0b", tag, nz, pkt_n, gap, err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    bit_in = 1'b0;
    bit_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({rx_data, rx_valid, rx_active, rx_eop, rx_err, rx_len} !== 23'd0) begin
      bad++;
      $display("FAIL reset_state: data=%02h v=%0b a=%0b e=%0b err=%0b len=%0d, required all 0",
               rx_data, rx_valid, rx_active, rx_eop, rx_err, rx_len);
    end
    rst_n = 1'b1;
    idle(2);

    // Basic three-byte packet.
    pkt[0] = 8'hC3; pkt[1] = 8'h5A; pkt[2] = 8'hA5; pkt_n = 3;
    run_packet(31, 0, "basic");

    // All-ones payload exercises stuffing.
    pkt[0] = 8'hFF; pkt[1] = 8'hFF; pkt_n = 2;
    run_packet(31, 0, "stuffed");

    // SYNC one zero short: nothing may happen.
    active_seen = 1'b0;
    repeat (SYNC_MIN - 1) drive_bit(1'b0);
    drive_bit(1'b1);
    pkt[0] = 8'hC3;
    for (int b = 0; b < 8; b++) drive_bit(pkt[0][b]);
    repeat (8) drive_bit(1'b1);
    idle(3);
    total++;
    if (active_seen) begin
      bad++;
      $display("FAIL short_sync: rx_active=1 seen, required 0");
    end
    check_drained("short_sync");
    $display("pkt short_sync: zeros=%0d bytes=0", SYNC_MIN - 1);

    // Empty packet.
    pkt_n = 0;
    run_packet(SYNC_MIN, 0, "empty");

    // Overflow: one byte more than MAX_B.
    for (int i = 0; i < 5; i++) pkt[i] = 8'($urandom);
    pkt_n = 5;
    run_packet(20, 0, "overflow");

    // Same packet as the first, with stalls.
    pkt[0] = 8'hC3; pkt[1] = 8'h5A; pkt[2] = 8'hA5; pkt_n = 3;
    run_packet(31, 30, "stalled");

    // Reset in the middle of the third byte.
    pkt[0] = 8'h3C; pkt[1] = 8'h96; pkt[2] = 8'h0F;
    push_ev(1'b0, pkt[0], 1'b0, 1);
    push_ev(1'b0, pkt[1], 1'b0, 2);
    repeat (16) drive_bit(1'b0);
    drive_bit(1'b1);
    stuff_ones = 0;
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 8; b++) send_data_bit(pkt[i][b]);
    for (int b = 0; b < 3; b++) send_data_bit(pkt[2][b]);
    rst_n = 1'b0;
    #1;
    total++;
    if ({rx_data, rx_valid, rx_active, rx_eop, rx_err, rx_len} !== 23'd0) begin
      bad++;
      $display("FAIL midreset_outputs: data=%02h v=%0b a=%0b e=%0b err=%0b len=%0d, required all 0",
               rx_data, rx_valid, rx_active, rx_eop, rx_err, rx_len);
    end
    line_prev  = 1'b0;
    stuff_ones = 0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    check_drained("midreset");
    $display("pkt midreset: bytes=2 then reset");

    // Random packets.
    for (int p = 0; p < 25; p++) begin
      pkt_n = $urandom_range(6);
      for (int i = 0; i < 8; i++) pkt[i] = 8'($urandom);
      run_packet($urandom_range(31, SYNC_MIN), ($urandom_range(1) != 0) ? 30 : 0, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
